pipeline_ctrl: RTL and testbench

Central stall/flush sequencer for the MangoMIPS32 five-stage pipeline. It collects stall requests from IF, ID, EX and MEM, plus the precise-exception request from MEM. It then drives per-register stall and flush vectors to the PC register and to the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers, along with the redirect PC. A small FSM defers an exception redirect until an in-flight instruction fetch retires. A stall-cycle counter feeds performance monitoring.

---
 rtl/pipeline_ctrl_pkg.sv | 28 ++
 rtl/pipeline_ctrl_if.sv | 42 ++++
 rtl/pipeline_ctrl.sv | 120 ++++++++++++
 tb/tb_pipeline_ctrl.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/pipeline_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_pkg
// Brief    : Shared widths, stall/flush bus index map and FSM encodings for
//            the pipeline stall/flush sequencer.
// Revision : 1.0 - initial release
// ============================================================================
package pipeline_ctrl_pkg;

  // One bit per pipeline register: PC, IF/ID, ID/EX, EX/MEM, MEM/WB
  localparam int unsigned STALL_W = 5;

  localparam int unsigned PC_IDX    = 0;
  localparam int unsigned IFID_IDX  = 1;
  localparam int unsigned IDEX_IDX  = 2;
  localparam int unsigned EXMEM_IDX = 3;
  localparam int unsigned MEMWB_IDX = 4;

  typedef logic [STALL_W-1:0] stall_bus_t;

  // RUN: normal operation; WAIT_IF: exception accepted, fetch still outstanding
  typedef enum logic [0:0] {
    ST_RUN     = 1'b0,
    ST_WAIT_IF = 1'b1
  } state_e;

endpackage : pipeline_ctrl_pkg
`default_nettype wire

// File: rtl/pipeline_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl_if
// Brief    : Request/control bundle between the pipeline stages and the
//            stall/flush sequencer.
// Revision : 1.0 - initial release
// ============================================================================
interface pipeline_ctrl_if;
  import pipeline_ctrl_pkg::*;

  // Requests from the pipeline stages
  logic        if_stallreq;
  logic        id_stallreq;
  logic        ex_stallreq;
  logic        mem_stallreq;
  logic        exc_req;
  logic [31:0] exc_pc;
  logic        cnt_clr;

  // Controls back to the pipeline registers
  stall_bus_t  stall;
  stall_bus_t  flush;
  logic [31:0] flush_pc;
  logic [31:0] stall_cnt;
  logic        busy_redirect;

  // Pipeline side: raises requests, consumes stall/flush
  modport master (
    output if_stallreq, id_stallreq, ex_stallreq, mem_stallreq,
    output exc_req, exc_pc, cnt_clr,
    input  stall, flush, flush_pc, stall_cnt, busy_redirect
  );

  // Sequencer side
  modport slave (
    input  if_stallreq, id_stallreq, ex_stallreq, mem_stallreq,
    input  exc_req, exc_pc, cnt_clr,
    output stall, flush, flush_pc, stall_cnt, busy_redirect
  );

endinterface : pipeline_ctrl_if
`default_nettype wire

// File: rtl/pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipeline_ctrl
// Brief    : Central stall/flush sequencer for a five-stage pipeline. Encodes
//            stage stall requests and precise exceptions into per-register
//            stall/flush vectors, defers an exception redirect until an
//            in-flight fetch retires, and counts PC-stall cycles.
// Revision : 1.0 - initial release
// ============================================================================
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  pipeline_ctrl_if.slave  bus
);

  state_e      state_q, state_d;
  logic [31:0] tgt_q, tgt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  stall_bus_t  w_stall;
  stall_bus_t  w_flush;
  logic [31:0] w_flush_target;
  logic [31:0] w_flush_pc;

  // Priority encoder and FSM next-state: exception beats every stall, and
  // among stalls the oldest requesting stage wins since it freezes the rest.
  always_comb begin
    w_stall        = '0;
    w_flush        = '0;
    w_flush_target = '0;
    state_d        = state_q;
    tgt_d          = tgt_q;

    unique case (state_q)
      ST_RUN: begin
        if (bus.exc_req) begin
          if (!bus.if_stallreq) begin
            // Whole pipeline drained, PC redirected this cycle
            w_flush        = 5'b11111;
            w_flush_target = bus.exc_pc;
          end else begin
            // Fetch cannot be aborted: kill downstream, hold PC, park target
            w_flush = 5'b11110;
            w_stall = 5'b00001;
            tgt_d   = bus.exc_pc;
            state_d = ST_WAIT_IF;
          end
        end else if (bus.mem_stallreq) begin
          w_stall = 5'b01111;
          w_flush = 5'b10000;
        end else if (bus.ex_stallreq) begin
          w_stall = 5'b00111;
          w_flush = 5'b01000;
        end else if (bus.id_stallreq) begin
          w_stall = 5'b00011;
          w_flush = 5'b00100;
        end else if (bus.if_stallreq) begin
          w_stall = 5'b00001;
          w_flush = 5'b00010;
        end
      end

      ST_WAIT_IF: begin
        // Pipeline is already empty, so exc_req is ignored here
        if (bus.if_stallreq) begin
          w_stall = 5'b00001;
          w_flush = 5'b00010;
        end else begin
          // Fetch retired: drop the fetched word and take the parked target
          w_flush        = 5'b00011;
          w_flush_target = tgt_q;
          state_d        = ST_RUN;
        end
      end

      default: state_d = ST_RUN;
    endcase

    // Reset silences every control output
    if (rst) begin
      w_stall = '0;
      w_flush = '0;
    end

    w_flush_pc = w_flush[PC_IDX] ? w_flush_target : 32'd0;
  end

  // Stall-cycle counter next value: clear beats increment, wraps naturally
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (bus.cnt_clr) begin
      stall_cnt_d = '0;
    end else if (w_stall[PC_IDX]) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // State, parked redirect target and counter registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_RUN;
      tgt_q       <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      tgt_q       <= tgt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.stall         = w_stall;
  assign bus.flush         = w_flush;
  assign bus.flush_pc      = w_flush_pc;
  assign bus.stall_cnt     = stall_cnt_q;
  assign bus.busy_redirect = (state_q == ST_WAIT_IF) && !rst;

endmodule : pipeline_ctrl
`default_nettype wire

// File: tb/tb_pipeline_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipeline_ctrl
// Brief    : Directed self-checking bench for pipeline_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipeline_ctrl;

  logic clk;
  logic rst;
  int   n_total;
  int   n_bad;

  pipeline_ctrl_if u_if ();

  pipeline_ctrl dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single comparison point: counts and reports
  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
    end
  endtask

  task automatic drive(input logic i_if, input logic i_id, input logic i_ex,
                       input logic i_mem, input logic i_exc, input logic [31:0] i_pc,
                       input logic i_clr);
    u_if.if_stallreq  = i_if;
    u_if.id_stallreq  = i_id;
    u_if.ex_stallreq  = i_ex;
    u_if.mem_stallreq = i_mem;
    u_if.exc_req      = i_exc;
    u_if.exc_pc       = i_pc;
    u_if.cnt_clr      = i_clr;
  endtask

  // Check the combinational outputs at the falling edge, then advance
  task automatic check_cycle(input string tag, input logic [4:0] e_stall,
                             input logic [4:0] e_flush, input logic [31:0] e_pc,
                             input logic e_busy);
    @(negedge clk);
    chk({tag, ".stall"}, {27'd0, u_if.stall}, {27'd0, e_stall});
    chk({tag, ".flush"}, {27'd0, u_if.flush}, {27'd0, e_flush});
    chk({tag, ".flush_pc"}, u_if.flush_pc, e_pc);
    chk({tag, ".busy"}, {31'd0, u_if.busy_redirect}, {31'd0, e_busy});
    @(posedge clk);
    #1;
  endtask

  task automatic check_cnt(input string tag, input logic [31:0] e_cnt);
    chk({tag, ".cnt"}, u_if.stall_cnt, e_cnt);
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst     = 1'b1;
    // Requests active during reset must not reach the outputs
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b0);
    check_cycle("rst_hold", 5'b00000, 5'b00000, 32'd0, 1'b0);
    check_cycle("rst_hold2", 5'b00000, 5'b00000, 32'd0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    check_cnt("after_rst", 32'd0);

    // Idle
    for (int i = 0; i < 10; i++) begin
      check_cycle("idle", 5'b00000, 5'b00000, 32'd0, 1'b0);
    end
    check_cnt("idle", 32'd0);

    // Concurrent ID + MEM: MEM wins
    drive(1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 32'd0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      check_cnt("conc_pre", i);
      check_cycle("conc", 5'b01111, 5'b10000, 32'd0, 1'b0);
    end
    check_cnt("conc", 32'd3);

    drive(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    check_cycle("id_only", 5'b00011, 5'b00100, 32'd0, 1'b0);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'd0, 1'b0);
    check_cycle("ex_over_id_if", 5'b00111, 5'b01000, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    check_cycle("if_only", 5'b00001, 5'b00010, 32'd0, 1'b0);
    check_cnt("after_stalls", 32'd6);

    // Clean exception overrides a simultaneous MEM stall
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 32'hBFC0_0380, 1'b0);
    check_cycle("exc_clean", 5'b00000, 5'b11111, 32'hBFC0_0380, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    check_cycle("exc_clean_after", 5'b00000, 5'b00000, 32'd0, 1'b0);
    check_cnt("exc_clean", 32'd6);

    // Clear wins over a concurrent stall
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b1);
    check_cycle("clr_stall", 5'b00001, 5'b00010, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    check_cnt("clr", 32'd0);

    // Deferred exception behind an outstanding fetch
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h8000_0180, 1'b0);
    check_cycle("defer_c0", 5'b00001, 5'b11110, 32'd0, 1'b0);
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 32'h1111_1111, 1'b0);
    for (int i = 1; i < 4; i++) begin
      check_cycle("defer_wait", 5'b00001, 5'b00010, 32'd0, 1'b1);
    end
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    check_cycle("defer_redirect", 5'b00000, 5'b00011, 32'h8000_0180, 1'b1);
    check_cycle("defer_done", 5'b00000, 5'b00000, 32'd0, 1'b0);
    check_cnt("defer", 32'd4);

    // Reset while parked in WAIT_IF abandons the redirect
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 32'h1234_5678, 1'b0);
    check_cycle("rw_enter", 5'b00001, 5'b11110, 32'd0, 1'b0);
    rst = 1'b1;
    check_cycle("rw_in_rst", 5'b00000, 5'b00000, 32'd0, 1'b0);
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    chk("rw.tgt_q", dut.tgt_q, 32'd0);
    check_cnt("rw", 32'd0);
    check_cycle("rw_no_redirect", 5'b00000, 5'b00000, 32'd0, 1'b0);

    // Counter wrap from all-ones
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    force dut.stall_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.stall_cnt_q;
    check_cnt("wrap_pre", 32'hFFFF_FFFF);
    check_cycle("wrap_stall", 5'b00001, 5'b00010, 32'd0, 1'b0);
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'd0, 1'b0);
    check_cnt("wrap", 32'd0);
    check_cycle("wrap_idle", 5'b00000, 5'b00000, 32'd0, 1'b0);
    check_cnt("wrap_hold", 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  // Global watchdog
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule : tb_pipeline_ctrl
`default_nettype wire
